// File: rtl/axis_uart_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream UART TX path among NUM_SRC sources.
// A grant lasts for a whole packet; a watchdog revokes it if the granted source stalls mid-packet.
module axis_uart_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int WIDTH        = 8,
    parameter int IDLE_TIMEOUT = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC*WIDTH-1:0]   s_axis_data,
    input  logic [NUM_SRC-1:0]         s_axis_valid,
    input  logic [NUM_SRC-1:0]         s_axis_last,
    output logic [NUM_SRC-1:0]         s_axis_ready,
    output logic [WIDTH-1:0]           m_axis_data,
    output logic                       m_axis_valid,
    output logic                       m_axis_last,
    input  logic                       m_axis_ready,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);
    localparam int GID_W = $clog2(NUM_SRC);
    localparam int SC_W  = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [SC_W-1:0]  STALL_LAST = (IDLE_TIMEOUT > 0) ? SC_W'(IDLE_TIMEOUT - 1) : '0;
    localparam logic [GID_W-1:0] LAST_SRC   = GID_W'(NUM_SRC - 1);

    typedef enum logic {IDLE, PASS} state_t;

    state_t           state;
    logic [GID_W-1:0] ptr;
    logic [GID_W-1:0] sel;
    logic [GID_W-1:0] next_ptr;
    logic [SC_W-1:0]  stall_cnt;
    logic             g_valid;
    logic             g_last;
    logic             xfer;
    int               idx;

    // Walk the search order backwards so the earliest requester after ptr wins.
    always_comb begin
        sel = ptr;
        idx = 0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_SRC;
            if (s_axis_valid[idx]) begin
                sel = GID_W'(idx);
            end
        end
    end

    assign g_valid  = s_axis_valid[grant_id];
    assign g_last   = s_axis_last[grant_id];
    assign xfer     = (state == PASS) && g_valid && m_axis_ready;
    assign next_ptr = (grant_id == LAST_SRC) ? '0 : grant_id + GID_W'(1);

    // Zero-latency pass-through of the granted source while a packet is open.
    always_comb begin
        m_axis_data  = '0;
        m_axis_valid = 1'b0;
        m_axis_last  = 1'b0;
        s_axis_ready = '0;
        if (state == PASS) begin
            m_axis_data            = s_axis_data[int'(grant_id)*WIDTH +: WIDTH];
            m_axis_valid           = g_valid;
            m_axis_last            = g_last;
            s_axis_ready[grant_id] = m_axis_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_id    <= '0;
            stall_cnt   <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|s_axis_valid) begin
                        grant_id  <= sel;
                        stall_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= PASS;
                    end
                end
                PASS: begin
                    if (xfer && g_last) begin
                        ptr       <= next_ptr;
                        stall_cnt <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if ((IDLE_TIMEOUT != 0) && !g_valid) begin
                        // Backpressure keeps valid high, so only a silent source counts here.
                        if (stall_cnt == STALL_LAST) begin
                            ptr         <= next_ptr;
                            stall_cnt   <= '0;
                            busy        <= 1'b0;
                            timeout_err <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            stall_cnt <= stall_cnt + SC_W'(1);
                        end
                    end else begin
                        stall_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_uart_arbiter.sv
// Scoreboard bench for axis_uart_arbiter: per-source beat memories drive the inputs and
// expected {grant, last, data} triples are queued in the order the arbitration must produce them.
module tb_axis_uart_arbiter;
    localparam int NS = 4;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NS*W-1:0] s_axis_data;
    logic [NS-1:0]   s_axis_valid;
    logic [NS-1:0]   s_axis_last;
    logic [NS-1:0]   s_axis_ready;
    logic [W-1:0]    m_axis_data;
    logic            m_axis_valid;
    logic            m_axis_last;
    logic            m_axis_ready;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout_err;

    always #5 clk = ~clk;

    axis_uart_arbiter #(.NUM_SRC(NS), .WIDTH(W), .IDLE_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid),
        .s_axis_last(s_axis_last), .s_axis_ready(s_axis_ready),
        .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
        .m_axis_last(m_axis_last), .m_axis_ready(m_axis_ready),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [8:0]  mem [NS][32];
    int          head [NS];
    int          len [NS];
    logic [10:0] exp_q [$];
    int          beat_cyc [$];
    int          want_cyc [$];
    int          cyc;
    logic        rdy_pat [64];
    logic        rst_pat [64];
    logic [NS-1:0] log_rdy [64];
    logic        log_busy [64];
    logic        log_terr [64];
    logic        log_mv [64];
    logic [1:0]  log_gid [64];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            if (head[i] < len[i]) begin
                s_axis_valid[i]      = 1'b1;
                s_axis_data[i*W +: W] = mem[i][head[i]][7:0];
                s_axis_last[i]       = mem[i][head[i]][8];
            end else begin
                s_axis_valid[i]      = 1'b0;
                s_axis_data[i*W +: W] = '0;
                s_axis_last[i]       = 1'b0;
            end
        end
    endtask

    task automatic src_pkt(input int s, input int base, input int n, input bit lst);
        for (int k = 0; k < n; k++) begin
            mem[s][len[s]] = {lst && (k == n - 1), 8'(base + k)};
            len[s]++;
        end
    endtask

    task automatic exp_pkt(input int s, input int base, input int n, input bit lst);
        logic [1:0] g;
        logic       l;
        logic [7:0] d;
        g = 2'(s);
        for (int k = 0; k < n; k++) begin
            l = lst && (k == n - 1);
            d = 8'(base + k);
            exp_q.push_back({g, l, d});
        end
    endtask

    // One clock: sample outputs at the falling edge, then advance sources after the rising edge.
    task automatic step();
        logic [NS-1:0] acc;
        logic [10:0]   e;
        @(negedge clk);
        acc           = s_axis_valid & s_axis_ready;
        log_rdy[cyc]  = s_axis_ready;
        log_busy[cyc] = busy;
        log_terr[cyc] = timeout_err;
        log_mv[cyc]   = m_axis_valid;
        log_gid[cyc]  = grant_id;
        if (m_axis_valid && m_axis_ready) begin
            beat_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check_eq("beat_expected", 32'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                check_eq("beat", 32'({grant_id, m_axis_last, m_axis_data}), 32'(e));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) if (acc[i]) head[i]++;
        cyc++;
        rst          = rst_pat[cyc];
        m_axis_ready = rdy_pat[cyc];
        drive();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic hard_reset();
        for (int i = 0; i < NS; i++) begin
            head[i] = 0;
            len[i]  = 0;
        end
        drive();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic start_test();
        cyc = 0;
        beat_cyc.delete();
        want_cyc.delete();
        for (int c = 0; c < 64; c++) begin
            rdy_pat[c]  = 1'b1;
            rst_pat[c]  = 1'b1;
            log_rdy[c]  = '0;
            log_busy[c] = 1'b0;
            log_terr[c] = 1'b0;
            log_mv[c]   = 1'b0;
            log_gid[c]  = '0;
        end
    endtask

    task automatic apply();
        rst          = rst_pat[0];
        m_axis_ready = rdy_pat[0];
        drive();
    endtask

    task automatic check_cycles(input string tag);
        check_eq({tag, "_nbeats"}, 32'(beat_cyc.size()), 32'(want_cyc.size()));
        for (int k = 0; k < want_cyc.size() && k < beat_cyc.size(); k++)
            check_eq({tag, "_cyc"}, 32'(beat_cyc[k]), 32'(want_cyc[k]));
    endtask

    function automatic int count_busy(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) if (log_busy[c]) n++;
        return n;
    endfunction

    function automatic int count_terr(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) if (log_terr[c]) n++;
        return n;
    endfunction

    initial begin
        rst          = 1'b0;
        m_axis_ready = 1'b1;
        s_axis_valid = '0;
        s_axis_data  = '0;
        s_axis_last  = '0;
        for (int i = 0; i < NS; i++) begin
            head[i] = 0;
            len[i]  = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_terr", 32'(timeout_err), 0);
        check_eq("rst_mvalid", 32'(m_axis_valid), 0);
        check_eq("rst_sready", 32'(s_axis_ready), 0);
        check_eq("rst_gid", 32'(grant_id), 0);

        // Single 3-byte packet from source 2.
        hard_reset(); start_test();
        src_pkt(2, 8'h41, 3, 1); exp_pkt(2, 8'h41, 3, 1);
        apply(); run(6);
        want_cyc = {1, 2, 3};
        check_cycles("t1");
        check_eq("t1_busy_cycles", 32'(count_busy(0, 5)), 3);
        check_eq("t1_drain", 32'(exp_q.size()), 0);

        // Pointer now at 3: source 3 must beat source 0.
        start_test();
        src_pkt(0, 8'hA0, 1, 1); src_pkt(3, 8'hB0, 1, 1);
        exp_pkt(3, 8'hB0, 1, 1); exp_pkt(0, 8'hA0, 1, 1);
        apply(); run(6);
        want_cyc = {1, 3};
        check_cycles("t1b");
        check_eq("t1b_drain", 32'(exp_q.size()), 0);

        // Sources 0 and 1 contend with 2-byte packets.
        hard_reset(); start_test();
        src_pkt(0, 8'h10, 2, 1); src_pkt(1, 8'h20, 2, 1);
        exp_pkt(0, 8'h10, 2, 1); exp_pkt(1, 8'h20, 2, 1);
        apply(); run(8);
        want_cyc = {1, 2, 4, 5};
        check_cycles("t2");
        check_eq("t2_src1_rdy_c1", 32'(log_rdy[1][1]), 0);
        check_eq("t2_src1_rdy_c2", 32'(log_rdy[2][1]), 0);
        check_eq("t2_drain", 32'(exp_q.size()), 0);

        // All four sources stream 1-byte packets carrying their own index.
        hard_reset(); start_test();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < NS; s++) begin
                src_pkt(s, s, 1, 1);
                exp_pkt(s, s, 1, 1);
            end
        apply(); run(18);
        for (int k = 0; k < 8; k++) want_cyc.push_back(1 + 2 * k);
        check_cycles("t3");
        check_eq("t3_drain", 32'(exp_q.size()), 0);

        // Backpressure on source 3 is not a stall.
        hard_reset(); start_test();
        rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b0;
        src_pkt(3, 8'h30, 2, 1); exp_pkt(3, 8'h30, 2, 1);
        apply(); run(7);
        want_cyc = {1, 4};
        check_cycles("t4");
        for (int c = 1; c <= 4; c++)
            check_eq("t4_sready", 32'(log_rdy[c]), 32'({rdy_pat[c], 3'b000}));
        check_eq("t4_terr", 32'(count_terr(0, 6)), 0);
        check_eq("t4_drain", 32'(exp_q.size()), 0);

        // Watchdog: source 1 goes silent after one beat, source 2 waits.
        hard_reset(); start_test();
        src_pkt(1, 8'h51, 1, 0); src_pkt(2, 8'h61, 1, 1);
        exp_pkt(1, 8'h51, 1, 0); exp_pkt(2, 8'h61, 1, 1);
        apply(); run(14);
        want_cyc = {1, 11};
        check_cycles("t5");
        check_eq("t5_busy_cycles", 32'(count_busy(1, 9)), 9);
        check_eq("t5_terr_c10", 32'(log_terr[10]), 1);
        check_eq("t5_busy_c10", 32'(log_busy[10]), 0);
        check_eq("t5_terr_count", 32'(count_terr(0, 13)), 1);
        check_eq("t5_drain", 32'(exp_q.size()), 0);

        // Reset during the second beat of source 2's 4-byte packet.
        hard_reset(); start_test();
        rst_pat[4] = 1'b0;
        src_pkt(1, 8'h60, 1, 1); src_pkt(1, 8'h80, 1, 1); src_pkt(2, 8'h70, 4, 1);
        exp_pkt(1, 8'h60, 1, 1); exp_pkt(2, 8'h70, 2, 0);
        exp_pkt(1, 8'h80, 1, 1); exp_pkt(2, 8'h72, 2, 1);
        apply(); run(12);
        want_cyc = {1, 3, 4, 6, 8, 9};
        check_cycles("t6");
        check_eq("t6_busy_c5", 32'(log_busy[5]), 0);
        check_eq("t6_gid_c5", 32'(log_gid[5]), 0);
        check_eq("t6_sready_c5", 32'(log_rdy[5]), 0);
        check_eq("t6_mvalid_c5", 32'(log_mv[5]), 0);
        check_eq("t6_drain", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axis_uart_arbiter.md
# axis_uart_arbiter

Packet-level round-robin arbiter that shares the single AXI-Stream FIFO/UART transmit path among NUM_SRC independent AXI-Stream sources. It sits between the stream producers and the FIFO/UART TX input.
- A grant is held for a whole packet, until the beat carrying `last` is accepted, so bytes of different packets never interleave on the UART line.
- A watchdog releases a grant when the granted source stalls mid-packet.

## Interface
Parameters:
- `NUM_SRC`, 4: number of source ports, 2..16.
- `WIDTH`, 8: data width per beat.
- `IDLE_TIMEOUT`, 1000: consecutive stall cycles that force a grant release; 0 disables the watchdog.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `s_axis_data`  in  NUM_SRC*WIDTH  source data; source i occupies bits [i*WIDTH +: WIDTH].
- `s_axis_valid`  in  NUM_SRC  per-source valid.
- `s_axis_last`  in  NUM_SRC  per-source end-of-packet.
- `s_axis_ready`  out  NUM_SRC  per-source ready.
- `m_axis_data`  out  WIDTH  data to the FIFO/UART TX.
- `m_axis_valid`  out  1  valid to the FIFO/UART TX.
- `m_axis_last`  out  1  last to the FIFO/UART TX.
- `m_axis_ready`  in  1  ready from the FIFO/UART TX.
- `grant_id`  out  clog2(NUM_SRC)  index of the current or most recent grant.
- `busy`  out  1  high while a packet is granted.
- `timeout_err`  out  1  one-cycle pulse when the watchdog revokes a grant.

## Operation
The state machine has two states: IDLE and PASS.

Registers:
- `ptr`, the round-robin priority pointer.
- `grant_id`.
- `stall_cnt`, width clog2(IDLE_TIMEOUT+1).

IDLE state:
- All `s_axis_ready` = 0 and `m_axis_valid` = 0.
- If any `s_axis_valid` bit is 1:
  - Select the first asserted source, searching ptr, ptr+1, … modulo NUM_SRC.
  - Register the selection into `grant_id`, clear `stall_cnt`, and go to PASS.

PASS state:
- Combinational pass-through from source g = `grant_id`:
  - `m_axis_data` = data[g], `m_axis_valid` = valid[g], `m_axis_last` = last[g].
  - `s_axis_ready[g]` = `m_axis_ready`; every other ready bit is 0.
- A beat transfers when valid[g] & `m_axis_ready`.
- A transfer with last[g] = 1 ends the packet:
  - Next state is IDLE.
  - `ptr` ← (g+1) mod NUM_SRC.
- Watchdog, active only when IDLE_TIMEOUT ≠ 0:
  - `stall_cnt` increments each cycle valid[g] = 0.
  - It clears on any cycle valid[g] = 1. Backpressure from `m_axis_ready` = 0 is legitimate and does not count as a stall.
  - When `stall_cnt` reaches IDLE_TIMEOUT-1 and valid[g] is still 0:
    - Next state is IDLE and `ptr` ← (g+1) mod NUM_SRC.
    - `timeout_err` is 1 for the following cycle.
    - The packet is truncated downstream with no `last`; that is accepted behaviour.
- Outputs in PASS:
  - `busy` = 1.
  - `grant_id` is stable for the whole packet and holds its value in IDLE.

Other rules:
- Sources that are not granted keep their valid/data pending. The arbiter never drops a beat.
- A source deasserting valid while not granted is legal.
- NUM_SRC that is not a power of two: the pointer and search wrap at NUM_SRC, not at 2^width.

## Timing
- Reset value of every output (`rst` = 0 at an edge):
  - state IDLE; `ptr` = 0, `grant_id` = 0, `stall_cnt` = 0.
  - `busy` = 0, `timeout_err` = 0, `m_axis_valid` = 0, `s_axis_ready` = 0.
- Reset mid-packet: the next cycle is IDLE with all ready bits 0. No further beats of that packet pass.
- Arbitration latency:
  - valid seen in IDLE at cycle n → grant registered at edge n+1.
  - The first beat can transfer in cycle n+1.
- Inter-packet gap: the last-beat transfer at cycle n → IDLE at n+1 → next grant at edge n+2. This gives exactly one bubble cycle between packets.
- Single-beat packet (last on the first beat): PASS lasts 1 cycle when `m_axis_ready` = 1.
- Fairness: with all sources continuously valid, grants rotate 0,1,…,NUM_SRC-1,0. No source waits more than NUM_SRC-1 packets.
- There is no register on the data/valid/ready path in PASS. The arbiter adds zero latency to beats after the grant.
- Timeout: the grant is revoked after exactly IDLE_TIMEOUT consecutive stall cycles. `timeout_err` rises in the first IDLE cycle.

## Test plan
- Reset, then source 2 sends a 3-byte packet 0x41,0x42,0x43 (last on 0x43), `m_axis_ready` = 1.
  - m side shows the same 3 bytes in consecutive cycles, starting 1 cycle after valid.
  - `grant_id` = 2 and `busy` is high for exactly 3 cycles.
  - `ptr` becomes 3.
- Sources 0 and 1 both valid from reset, each sending 2-byte packets.
  - Output order: source 0 packet, 1 bubble cycle, then source 1 packet.
  - Source 1 ready stays 0 throughout source 0's packet.
- All 4 sources continuously send 1-byte packets (data = source index).
  - Output sequence is 0x00,0x01,0x02,0x03,0x00,… with one bubble between beats.
- Source 3 granted, `m_axis_ready` toggles 1,0,0,1 across a 2-byte packet.
  - No beat lost or duplicated, `s_axis_ready[3]` mirrors `m_axis_ready`.
  - `timeout_err` stays 0.
- IDLE_TIMEOUT = 8; source 1 sends 1 byte without last, then holds valid low.
  - After 8 stall cycles, `timeout_err` pulses for 1 cycle and `busy` = 0.
  - Pending source 2 is granted next.
- `rst` driven low during the second beat of a 4-byte packet.
  - Next cycle: `busy` = 0, `grant_id` = 0, all ready bits 0.
  - After release, arbitration restarts from source 0.
